// File: rtl/fsm_input_cond.sv
// ---------------------------------------------------------------------------
// fsm_input_cond
//
// Input conditioner for the two-input control FSM. Each raw asynchronous
// input (button/switch) is synchronized, debounced by a small per-channel
// state machine with a stability counter, and presented as a clean level
// plus a one-cycle rising-edge pulse. Channels I and J are identical and
// fully independent.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth per channel (>= 2)
//   DEB_CYCLES   consecutive identical synchronized samples needed to
//                change a debounced level (>= 1)
//   CW           stability counter width (derived)
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   i_raw       raw asynchronous input, channel I
//   j_raw       raw asynchronous input, channel J
//   i           debounced level, channel I
//   j           debounced level, channel J
//   i_rise      one-cycle pulse when i goes 0->1
//   j_rise      one-cycle pulse when j goes 0->1
//   glitch_cnt  (only with FSM_INPUT_COND_GLITCH_CNT_EN defined) saturating
//               8-bit count of aborted debounce checks on either channel
// ---------------------------------------------------------------------------
module fsm_input_cond #(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 4,
   localparam int CW         = $clog2(DEB_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_raw,
   input  logic       j_raw,
   output logic       i,
   output logic       j,
   output logic       i_rise,
   output logic       j_rise
`ifdef FSM_INPUT_COND_GLITCH_CNT_EN
   ,
   output logic [7:0] glitch_cnt
`endif
);

   typedef enum logic [1:0] {
      LOW      = 2'd0,
      RISE_CHK = 2'd1,
      HIGH     = 2'd2,
      FALL_CHK = 2'd3
   } deb_state_t;

   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [1:0] raw_in;
   logic [1:0] deb;
   logic [1:0] rise;
`ifdef FSM_INPUT_COND_GLITCH_CNT_EN
   logic [1:0] abort;
`endif

   assign raw_in = {j_raw, i_raw};

   // One identical conditioning pipeline per channel: index 0 is I, 1 is J.
   for (genvar ch = 0; ch < 2; ch++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      deb_state_t             state_q, state_d;
      logic [CW-1:0]          cnt_q, cnt_d;
      logic                   out_d, out_q, rise_q;

      // Plain flop chain to resolve metastability on the raw input; the
      // last stage is the only one the debounce logic is allowed to see.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in[ch]};
         end
      end

      assign s = sync_q[SYNC_STAGES-1];

      // Debounce decisions. A CHK state counts how many identical samples
      // have been seen in a row; the first opposite sample throws the check
      // away and falls back to the stable state it came from. With
      // DEB_CYCLES=1 the single sample is already enough, so the CHK
      // states are skipped entirely.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         unique case (state_q)
            LOW: begin
               if (s) begin
                  if (DEB_CYCLES == 1) begin
                     state_d = HIGH;
                  end else begin
                     state_d = RISE_CHK;
                     cnt_d   = CW'(1);
                  end
               end
            end
            RISE_CHK: begin
               if (!s) begin
                  state_d = LOW;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = HIGH;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            HIGH: begin
               if (!s) begin
                  if (DEB_CYCLES == 1) begin
                     state_d = LOW;
                  end else begin
                     state_d = FALL_CHK;
                     cnt_d   = CW'(1);
                  end
               end
            end
            FALL_CHK: begin
               if (s) begin
                  state_d = HIGH;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = LOW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = LOW;
               cnt_d   = '0;
            end
         endcase
      end

      // The level is decoded from the next state and registered, so it
      // switches on the same edge as the state itself and never glitches.
      // The rise pulse fires on the first cycle the registered level is 1.
      assign out_d = (state_d == HIGH) || (state_d == FALL_CHK);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            rise_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= out_d & ~out_q;
         end
      end

      assign deb[ch]  = out_q;
      assign rise[ch] = rise_q;

`ifdef FSM_INPUT_COND_GLITCH_CNT_EN
      // A check is aborted when an opposite sample arrives mid-check.
      assign abort[ch] = ((state_q == RISE_CHK) && !s) ||
                         ((state_q == FALL_CHK) &&  s);
`endif
   end

   assign i      = deb[0];
   assign j      = deb[1];
   assign i_rise = rise[0];
   assign j_rise = rise[1];

`ifdef FSM_INPUT_COND_GLITCH_CNT_EN
   // Both channels can abort on the same edge, so the two abort flags are
   // summed in a 9-bit adder and the result clamped at 255.
   logic [8:0] glitch_sum;

   assign glitch_sum = {1'b0, glitch_cnt} + 9'(abort[0]) + 9'(abort[1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         glitch_cnt <= 8'd0;
      end else if (glitch_sum > 9'd255) begin
         glitch_cnt <= 8'hFF;
      end else begin
         glitch_cnt <= glitch_sum[7:0];
      end
   end
`endif

endmodule

// File: tb/tb_fsm_input_cond.sv
// ---------------------------------------------------------------------------
// tb_fsm_input_cond
//
// Bench for fsm_input_cond. A behavioural model tracks, per channel, how
// many consecutive synchronized samples disagree with the current level and
// flips the level once that run reaches DEB_CYCLES. The DUT is compared
// against the model on every falling edge, and a set of directed scenarios
// pins literal expectations (reset, latency, glitch reject, bounce,
// simultaneous inputs, async reset mid-check). Define
// FSM_INPUT_COND_GLITCH_CNT_EN to also check glitch_cnt.
// ---------------------------------------------------------------------------
module tb_fsm_input_cond;

   localparam int SYNC_STAGES = 2;
   localparam int DEB_CYCLES  = 4;
   localparam int LAT         = SYNC_STAGES + DEB_CYCLES;

   logic clk;
   logic rst_n;
   logic i_raw;
   logic j_raw;
   logic i;
   logic j;
   logic i_rise;
   logic j_rise;
`ifdef FSM_INPUT_COND_GLITCH_CNT_EN
   logic [7:0] glitch_cnt;
`endif

   int testsRun = 0;
   int testsFailed = 0;

   fsm_input_cond #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_raw     (i_raw),
      .j_raw     (j_raw),
      .i         (i),
      .j         (j),
      .i_rise    (i_rise),
      .j_rise    (j_rise)
`ifdef FSM_INPUT_COND_GLITCH_CNT_EN
      ,
      .glitch_cnt(glitch_cnt)
`endif
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Behavioural model. Each raw input reaches the debouncer SYNC_STAGES
   // edges after it was sampled (modelled as a queue). The level flips
   // once DEB_CYCLES disagreeing samples arrive in a row; an agreeing
   // sample in the middle of such a run is a rejected glitch.
   // ------------------------------------------------------------------
   bit mPipeI[$];
   bit mPipeJ[$];
   bit mOut[2];
   bit mRise[2];
   int mRun[2];
   int mGlitch;
   bit sNow[2];

   task automatic modelStep(input int c, input bit s);
      mRise[c] = 1'b0;
      if (s != mOut[c]) begin
         mRun[c] = mRun[c] + 1;
         if (mRun[c] == DEB_CYCLES) begin
            mOut[c]  = s;
            mRise[c] = s;
            mRun[c]  = 0;
         end
      end else begin
         if (mRun[c] > 0 && mGlitch < 255) mGlitch = mGlitch + 1;
         mRun[c] = 0;
      end
   endtask

   // Model update on every rising edge, cleared immediately by reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mPipeI = {};
         mPipeJ = {};
         for (int k = 0; k < SYNC_STAGES; k++) begin
            mPipeI.push_back(1'b0);
            mPipeJ.push_back(1'b0);
         end
         for (int c = 0; c < 2; c++) begin
            mOut[c]  = 1'b0;
            mRise[c] = 1'b0;
            mRun[c]  = 0;
         end
         mGlitch = 0;
      end else begin
         sNow[0] = mPipeI.pop_front();
         sNow[1] = mPipeJ.pop_front();
         mPipeI.push_back(i_raw);
         mPipeJ.push_back(j_raw);
         modelStep(0, sNow[0]);
         modelStep(1, sNow[1]);
      end
   end

   // One comparison with the shared pass/fail bookkeeping.
   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun = testsRun + 1;
      if (actual != expected) begin
         testsFailed = testsFailed + 1;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // Continuous scoreboard: every falling edge, DUT against model.
   always @(negedge clk) begin
      checkOutput("mdl_i", int'(i), int'(mOut[0]));
      checkOutput("mdl_j", int'(j), int'(mOut[1]));
      checkOutput("mdl_i_rise", int'(i_rise), int'(mRise[0]));
      checkOutput("mdl_j_rise", int'(j_rise), int'(mRise[1]));
`ifdef FSM_INPUT_COND_GLITCH_CNT_EN
      checkOutput("mdl_glitch", int'(glitch_cnt), mGlitch);
`endif
   end

   // Drive both raw inputs (called just after a falling edge) and hold
   // them for the given number of cycles.
   task automatic applyStimulus(input bit iv, input bit jv, input int cycles);
      i_raw = iv;
      j_raw = jv;
      repeat (cycles) @(negedge clk);
   endtask

   // Inputs were just changed at a falling edge: the level must hold its
   // old value after edges 1..LAT-1 and show the new value after edge LAT,
   // with a rise pulse only on that edge and only for a 0->1 change.
   task automatic expectLatency(input string tag, input bit newVal, input bit bothCh);
      for (int e = 1; e <= LAT + 1; e++) begin
         @(negedge clk);
         checkOutput({tag, "_i"}, int'(i), (e >= LAT) ? int'(newVal) : int'(!newVal));
         checkOutput({tag, "_i_rise"}, int'(i_rise), int'(newVal && e == LAT));
         if (bothCh) begin
            checkOutput({tag, "_j"}, int'(j), (e >= LAT) ? int'(newVal) : int'(!newVal));
            checkOutput({tag, "_j_rise"}, int'(j_rise), int'(newVal && e == LAT));
         end
      end
   endtask

   // Directed scenarios followed by a randomized soak.
   initial begin
      int remI;
      int remJ;
      bit vI;
      bit vJ;

      rst_n = 1'b0;
      i_raw = 1'b1;
      j_raw = 1'b1;
      repeat (3) @(negedge clk);

      // Reset held with both raw inputs high: everything stays 0.
      checkOutput("rst_i", int'(i), 0);
      checkOutput("rst_j", int'(j), 0);
      checkOutput("rst_i_rise", int'(i_rise), 0);
      checkOutput("rst_j_rise", int'(j_rise), 0);
`ifdef FSM_INPUT_COND_GLITCH_CNT_EN
      checkOutput("rst_glitch", int'(glitch_cnt), 0);
`endif

      // Release reset: both channels rise after the 6th edge.
      rst_n = 1'b1;
      expectLatency("rstRel", 1'b1, 1'b1);

      // Clean release of both channels.
      i_raw = 1'b0;
      j_raw = 1'b0;
      expectLatency("relBoth", 1'b0, 1'b1);

      // Clean press of I for 20 cycles, then release.
      i_raw = 1'b1;
      expectLatency("press", 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 20 - (LAT + 1));
      checkOutput("press_hold_i", int'(i), 1);
      checkOutput("press_hold_j", int'(j), 0);
      i_raw = 1'b0;
      expectLatency("release", 1'b0, 1'b0);

      // Glitch reject: 3-cycle pulse from a fresh reset never reaches i.
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 2);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 2);
      applyStimulus(1'b1, 1'b0, 3);
      i_raw = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         checkOutput("glitch_i", int'(i), 0);
         checkOutput("glitch_i_rise", int'(i_rise), 0);
      end
`ifdef FSM_INPUT_COND_GLITCH_CNT_EN
      checkOutput("glitch_cnt_one", int'(glitch_cnt), 1);
`endif

      // Bounce on release: i only falls after 4 consecutive synced zeros.
      applyStimulus(1'b1, 1'b0, 8);
      checkOutput("bounce_pre_i", int'(i), 1);
      for (int n = 0; n < 4; n++) begin
         applyStimulus(n[0], 1'b0, 1);
         checkOutput("bounce_hold_i", int'(i), 1);
         checkOutput("bounce_hold_i_rise", int'(i_rise), 0);
      end
      i_raw = 1'b0;
      expectLatency("bounce", 1'b0, 1'b0);
`ifdef FSM_INPUT_COND_GLITCH_CNT_EN
      checkOutput("glitch_cnt_three", int'(glitch_cnt), 3);
`endif

      // Simultaneous rise on both channels.
      i_raw = 1'b1;
      j_raw = 1'b1;
      expectLatency("simul", 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 8);

      // Async reset mid-check: J is high, I is in RISE_CHK with cnt=2.
      applyStimulus(1'b0, 1'b1, 8);
      checkOutput("arst_pre_j", int'(j), 1);
      i_raw = 1'b1;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_i", int'(i), 0);
      checkOutput("arst_j", int'(j), 0);
      checkOutput("arst_j_rise", int'(j_rise), 0);
      @(negedge clk);
      rst_n = 1'b1;
      expectLatency("postRst", 1'b1, 1'b1);

      // Randomized soak: mix of short (glitchy) and long (stable) runs.
      vI   = i_raw;
      vJ   = j_raw;
      remI = 0;
      remJ = 0;
      for (int n = 0; n < 3000; n++) begin
         if (remI == 0) begin
            vI   = !vI;
            remI = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 14));
         end
         if (remJ == 0) begin
            vJ   = !vJ;
            remJ = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 14));
         end
         remI = remI - 1;
         remJ = remJ - 1;
         applyStimulus(vI, vJ, 1);
      end
      applyStimulus(1'b0, 1'b0, 12);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/fsm_input_cond.md
Name: fsm_input_cond

Overview:
Input conditioner that sits directly upstream of the two-input control FSM. It turns two raw asynchronous inputs (buttons/switches) into the clean, debounced `i`/`j` levels that FSM consumes, plus one-cycle rising-edge pulses. Each channel has its own synchronizer, debounce state machine and stability counter. Both channels are identical and independent.

Parameters:
- SYNC_STAGES, 2: synchronizer flop depth per channel; legal range >= 2.
- DEB_CYCLES, 4: consecutive identical synchronized samples required to change a debounced output; legal range >= 1.
- CW, $clog2(DEB_CYCLES+1): stability counter width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_raw  input  1  raw asynchronous input, channel I.
- j_raw  input  1  raw asynchronous input, channel J.
- i  output  1  debounced level, channel I (feeds FSM input `i`).
- j  output  1  debounced level, channel J (feeds FSM input `j`).
- i_rise  output  1  one-cycle pulse when `i` goes 0->1.
- j_rise  output  1  one-cycle pulse when `j` goes 0->1.

Behaviour:
- Reset (`rst_n`=0, asynchronous): all synchronizer flops 0, state LOW, counter 0, `i`/`j`/`i_rise`/`j_rise`=0. Deassertion takes effect at the next clk edge. Reset mid-debounce aborts it with no output glitch.
- Synchronizer: the raw input is shifted through SYNC_STAGES flops. `s` is the last stage. No logic between the stages.
- Per-channel FSM; the registered state and counter update on clk:
  - LOW: output 0. If s=1: go to HIGH when DEB_CYCLES=1, else go to RISE_CHK and load cnt=1.
  - RISE_CHK: output 0.
    - s=0: go to LOW, cnt=0.
    - s=1 and cnt=DEB_CYCLES-1: go to HIGH.
    - Otherwise: cnt++.
  - HIGH: output 1. If s=0: go to LOW when DEB_CYCLES=1, else go to FALL_CHK and load cnt=1.
  - FALL_CHK: output 1.
    - s=1: go to HIGH, cnt=0.
    - s=0 and cnt=DEB_CYCLES-1: go to LOW.
    - Otherwise: cnt++.
- Debounced output is a registered decode: 1 in HIGH or FALL_CHK.
- Latency: raw held stable from before edge k changes the output after edge k+SYNC_STAGES+DEB_CYCLES-1. With defaults, this is the 6th sampling edge.
- Any opposite sample during a CHK state aborts the check and returns to the prior stable state. Pulses shorter than DEB_CYCLES synchronized cycles never reach the output.
- The counter never exceeds DEB_CYCLES-1; there is no wrap.
- `i_rise`/`j_rise` are registered and high for exactly one cycle, on the cycle the output first reads 1. They never assert on falling edges. Back-to-back rises are separated by at least 2*DEB_CYCLES cycles.
- Channels are fully independent. Simultaneous transitions on both raw inputs produce simultaneous output changes and simultaneous pulses.

Optional Feature:
Macro: FSM_INPUT_COND_GLITCH_CNT_EN.
- Defined:
  - Adds output `glitch_cnt`, 8 bits.
  - Incremented by 1 for each aborted check on either channel (RISE_CHK->LOW or FALL_CHK->HIGH).
  - If both channels abort in the same cycle, it increments by 2.
  - Saturates at 255.
  - Reset value 0.
- Undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with i_raw=j_raw=1 -> all outputs 0. Deassert -> `i` rises after the 6th edge and `i_rise`=1 for exactly one cycle (defaults).
- Glitch reject: i_raw high for 3 cycles then low (defaults) -> `i` stays 0, `i_rise` stays 0, `glitch_cnt`=1 when the macro is defined.
- Clean press/release: i_raw high for 20 cycles then low -> `i` high 6 edges after the rise, low 6 edges after the fall, a single `i_rise` pulse.
- Bounce on release: while i=1, j_raw-independent i_raw toggles 0,1,0,1 then stays 0 -> `i` falls only after 4 consecutive synced 0 samples; no `i_rise`.
- Simultaneous: i_raw and j_raw rise on the same edge -> `i`/`j` and `i_rise`/`j_rise` change on the same cycle.
- Async reset mid-check: assert rst_n=0 asynchronously while in RISE_CHK with cnt=2 -> outputs 0 immediately. After release, a full SYNC_STAGES+DEB_CYCLES window is needed before `i` rises.
